// File: rtl/axi4_lite_mst_arbiter_if.sv
// AXI4-Lite bundle shared by the master port of the arbiter and the slave it drives.
// All five channels are carried; protection is fixed at zero by the master.
interface axi4_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_lite_mst_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ command
// sources; exactly one single-beat transaction is in flight at a time.
module axi4_lite_mst_arbiter #(
   parameter int NUM_REQ                  = 2,
   parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
   parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
   input  logic                                                 i_clk,
   input  logic                                                 i_sync_rst,
   input  logic [NUM_REQ-1:0]                                   i_req_valid,
   output logic [NUM_REQ-1:0]                                   o_req_ready,
   input  logic [NUM_REQ-1:0]                                   i_req_we,
   input  logic [NUM_REQ*AXI4_LITE_ADDR_BIT_WIDTH-1:0]          i_req_addr,
   input  logic [NUM_REQ*AXI4_LITE_DATA_BIT_WIDTH-1:0]          i_req_wdata,
   input  logic [NUM_REQ*(AXI4_LITE_DATA_BIT_WIDTH/8)-1:0]      i_req_wstrb,
   output logic [NUM_REQ-1:0]                                   o_rsp_valid,
   output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]                  o_rsp_rdata,
   output logic [1:0]                                           o_rsp_resp,
   axi4_lite_if.master                                          if_m_axi4_lite
);
   localparam int ADDR_W = AXI4_LITE_ADDR_BIT_WIDTH;
   localparam int DATA_W = AXI4_LITE_DATA_BIT_WIDTH;
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_WR_B  = 3'd2,
      S_RD_AR = 3'd3,
      S_RD_R  = 3'd4,
      S_RSP   = 3'd5
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [IDX_W-1:0]    ptr_r, ptr_nxt_s;
   logic [IDX_W-1:0]    owner_r, owner_nxt_s;
   logic                we_r, we_nxt_s;
   logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
   logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
   logic [STRB_W-1:0]   wstrb_r, wstrb_nxt_s;
   logic                awvalid_r, awvalid_nxt_s;
   logic                wvalid_r, wvalid_nxt_s;
   logic                bready_r, bready_nxt_s;
   logic                arvalid_r, arvalid_nxt_s;
   logic                rready_r, rready_nxt_s;
   logic [NUM_REQ-1:0]  rsp_valid_r, rsp_valid_nxt_s;
   logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_nxt_s;
   logic [1:0]          rsp_resp_r, rsp_resp_nxt_s;

   logic [IDX_W-1:0]    grant_idx_s;
   logic                grant_found_s;
   logic                accept_s;
   int                  cand_s;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin search: first valid requester at or after the pointer, wrapping.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_s        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = (int'(ptr_r) + i) % NUM_REQ;
         if (!grant_found_s && i_req_valid[cand_s[IDX_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s[IDX_W-1:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign accept_s    = (state_r == S_IDLE) && !i_sync_rst && grant_found_s;
   assign o_req_ready = accept_s ? onehot(grant_idx_s) : '0;

   // Next-state and next-register logic for the transaction sequencer.
   always_comb begin
      state_nxt_s     = state_r;
      ptr_nxt_s       = ptr_r;
      owner_nxt_s     = owner_r;
      we_nxt_s        = we_r;
      addr_nxt_s      = addr_r;
      wdata_nxt_s     = wdata_r;
      wstrb_nxt_s     = wstrb_r;
      awvalid_nxt_s   = awvalid_r;
      wvalid_nxt_s    = wvalid_r;
      bready_nxt_s    = bready_r;
      arvalid_nxt_s   = arvalid_r;
      rready_nxt_s    = rready_r;
      rsp_valid_nxt_s = '0;
      rsp_rdata_nxt_s = rsp_rdata_r;
      rsp_resp_nxt_s  = rsp_resp_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               owner_nxt_s = grant_idx_s;
               we_nxt_s    = i_req_we[grant_idx_s];
               addr_nxt_s  = i_req_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
               wdata_nxt_s = i_req_wdata[int'(grant_idx_s)*DATA_W +: DATA_W];
               wstrb_nxt_s = i_req_wstrb[int'(grant_idx_s)*STRB_W +: STRB_W];
               ptr_nxt_s   = (int'(grant_idx_s) == NUM_REQ - 1) ? '0 : grant_idx_s + 1'b1;
               if (i_req_we[grant_idx_s]) begin
                  state_nxt_s   = S_WR;
                  awvalid_nxt_s = 1'b1;
                  wvalid_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s   = S_RD_AR;
                  arvalid_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WR: begin
            // AW and W complete independently, in either order or together.
            if (awvalid_r && if_m_axi4_lite.awready) begin
               awvalid_nxt_s = 1'b0;
            end else begin
               awvalid_nxt_s = awvalid_r;
            end
            if (wvalid_r && if_m_axi4_lite.wready) begin
               wvalid_nxt_s = 1'b0;
            end else begin
               wvalid_nxt_s = wvalid_r;
            end
            if (!awvalid_nxt_s && !wvalid_nxt_s) begin
               state_nxt_s  = S_WR_B;
               bready_nxt_s = 1'b1;
            end else begin
               state_nxt_s = S_WR;
            end
         end
         S_WR_B: begin
            if (if_m_axi4_lite.bvalid && bready_r) begin
               bready_nxt_s    = 1'b0;
               rsp_resp_nxt_s  = if_m_axi4_lite.bresp;
               rsp_rdata_nxt_s = '0;
               rsp_valid_nxt_s = onehot(owner_r);
               state_nxt_s     = S_RSP;
            end else begin
               state_nxt_s = S_WR_B;
            end
         end
         S_RD_AR: begin
            if (arvalid_r && if_m_axi4_lite.arready) begin
               arvalid_nxt_s = 1'b0;
               rready_nxt_s  = 1'b1;
               state_nxt_s   = S_RD_R;
            end else begin
               state_nxt_s = S_RD_AR;
            end
         end
         S_RD_R: begin
            if (if_m_axi4_lite.rvalid && rready_r) begin
               rready_nxt_s    = 1'b0;
               rsp_resp_nxt_s  = if_m_axi4_lite.rresp;
               rsp_rdata_nxt_s = if_m_axi4_lite.rdata;
               rsp_valid_nxt_s = onehot(owner_r);
               state_nxt_s     = S_RSP;
            end else begin
               state_nxt_s = S_RD_R;
            end
         end
         S_RSP: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         state_r     <= S_IDLE;
         ptr_r       <= '0;
         owner_r     <= '0;
         we_r        <= 1'b0;
         addr_r      <= '0;
         wdata_r     <= '0;
         wstrb_r     <= '0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         rsp_valid_r <= '0;
         rsp_rdata_r <= '0;
         rsp_resp_r  <= 2'b00;
      end else begin
         state_r     <= state_nxt_s;
         ptr_r       <= ptr_nxt_s;
         owner_r     <= owner_nxt_s;
         we_r        <= we_nxt_s;
         addr_r      <= addr_nxt_s;
         wdata_r     <= wdata_nxt_s;
         wstrb_r     <= wstrb_nxt_s;
         awvalid_r   <= awvalid_nxt_s;
         wvalid_r    <= wvalid_nxt_s;
         bready_r    <= bready_nxt_s;
         arvalid_r   <= arvalid_nxt_s;
         rready_r    <= rready_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_rdata_r <= rsp_rdata_nxt_s;
         rsp_resp_r  <= rsp_resp_nxt_s;
      end
   end

   assign if_m_axi4_lite.awaddr  = addr_r;
   assign if_m_axi4_lite.awprot  = 3'b000;
   assign if_m_axi4_lite.awvalid = awvalid_r;
   assign if_m_axi4_lite.wdata   = wdata_r;
   assign if_m_axi4_lite.wstrb   = wstrb_r;
   assign if_m_axi4_lite.wvalid  = wvalid_r;
   assign if_m_axi4_lite.bready  = bready_r;
   assign if_m_axi4_lite.araddr  = addr_r;
   assign if_m_axi4_lite.arprot  = 3'b000;
   assign if_m_axi4_lite.arvalid = arvalid_r;
   assign if_m_axi4_lite.rready  = rready_r;

   assign o_rsp_valid = rsp_valid_r;
   assign o_rsp_rdata = rsp_rdata_r;
   assign o_rsp_resp  = rsp_resp_r;
endmodule

// File: tb/tb_axi4_lite_mst_arbiter.sv
// Randomised bench for axi4_lite_mst_arbiter: a transaction-timeline model predicts
// every output each cycle, and a bench-driven slave follows that same timeline.
module tb_axi4_lite_mst_arbiter;
   localparam int NUM_REQ = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic                  i_clk;
   logic                  i_sync_rst;
   logic [NUM_REQ-1:0]    i_req_valid;
   logic [NUM_REQ-1:0]    o_req_ready;
   logic [NUM_REQ-1:0]    i_req_we;
   logic [NUM_REQ*AW-1:0] i_req_addr;
   logic [NUM_REQ*DW-1:0] i_req_wdata;
   logic [NUM_REQ*SW-1:0] i_req_wstrb;
   logic [NUM_REQ-1:0]    o_rsp_valid;
   logic [DW-1:0]         o_rsp_rdata;
   logic [1:0]            o_rsp_resp;

   axi4_lite_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

   axi4_lite_mst_arbiter #(
      .NUM_REQ(NUM_REQ), .AXI4_LITE_ADDR_BIT_WIDTH(AW), .AXI4_LITE_DATA_BIT_WIDTH(DW)
   ) dut (
      .i_clk(i_clk), .i_sync_rst(i_sync_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
      .if_m_axi4_lite(axi)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct { bit we; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } cmd_t;
   typedef struct { int own; logic [31:0] rdata; logic [1:0] resp; int acc; int rsp; } log_t;

   cmd_t        req_q [NUM_REQ][$];
   bit          pend [NUM_REQ];
   cmd_t        cur [NUM_REQ];
   int          gap [NUM_REQ];
   logic [31:0] mem [16];
   log_t        rsp_log [$];
   int          grant_log [$];

   // transaction model: one in flight, described by its handshake cycles
   bit          busy;
   int          ptr_m;
   int          cyc;
   bit          t_we;
   int          t_own;
   logic [31:0] t_addr, t_data, t_rdata;
   logic [3:0]  t_strb;
   logic [1:0]  t_resp;
   int          t_acc, t_aw, t_w, t_b, t_ar, t_r, t_rsp;

   bit cfg_rand;
   int cfg_daw, cfg_dw, cfg_db, cfg_dar, cfg_dr, cfg_resp, cfg_gap_max;
   bit rst_req;
   int checks, errors;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int dly(input int fixed_val);
      return cfg_rand ? int'($urandom_range(0, 3)) : fixed_val;
   endfunction

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.we   = 1'($urandom_range(0, 1));
      c.addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      c.data = $urandom;
      c.strb = 4'($urandom_range(1, 15));
      return c;
   endfunction

   function automatic cmd_t mk(input bit we, input logic [31:0] addr, input logic [31:0] data);
      cmd_t c;
      c.we = we; c.addr = addr; c.data = data; c.strb = 4'hF;
      return c;
   endfunction

   task automatic step();
      logic [NUM_REQ-1:0] exp_ready, exp_rsp;
      bit rst_now, e_aw, e_w, e_b, e_ar, e_r;
      int win, mx;
      @(negedge i_clk);
      rst_now    = rst_req;
      i_sync_rst = rst_now;
      for (int n = 0; n < NUM_REQ; n++) begin
         i_req_valid[n]            = pend[n];
         i_req_we[n]               = cur[n].we;
         i_req_addr[n*AW +: AW]    = cur[n].addr;
         i_req_wdata[n*DW +: DW]   = cur[n].data;
         i_req_wstrb[n*SW +: SW]   = cur[n].strb;
      end
      mx = (t_aw > t_w) ? t_aw : t_w;
      // slave: ready exactly at the scheduled handshake, random when no valid can be pending
      axi.awready = (busy && t_we && cyc <= t_aw) ? (cyc == t_aw) : 1'($urandom_range(0, 1));
      axi.wready  = (busy && t_we && cyc <= t_w)  ? (cyc == t_w)  : 1'($urandom_range(0, 1));
      axi.arready = (busy && !t_we && cyc <= t_ar) ? (cyc == t_ar) : 1'($urandom_range(0, 1));
      axi.bvalid  = busy && t_we && (cyc == t_b);
      axi.bresp   = t_resp;
      axi.rvalid  = busy && !t_we && (cyc == t_r);
      axi.rresp   = t_resp;
      if (busy && !t_we && cyc == t_r) t_rdata = mem[t_addr[5:2]];
      axi.rdata   = axi.rvalid ? t_rdata : $urandom;
      #1;
      win = -1;
      if (!busy && !rst_now) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = (ptr_m + i) % NUM_REQ;
            if (win < 0 && pend[c]) win = c;
         end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      check("req_ready", o_req_ready, exp_ready);
      check("req_ready_onehot0", $onehot0(o_req_ready), 1'b1);
      e_aw = busy && t_we && cyc > t_acc && cyc <= t_aw;
      e_w  = busy && t_we && cyc > t_acc && cyc <= t_w;
      e_b  = busy && t_we && cyc > mx && cyc <= t_b;
      e_ar = busy && !t_we && cyc > t_acc && cyc <= t_ar;
      e_r  = busy && !t_we && cyc > t_ar && cyc <= t_r;
      check("awvalid", axi.awvalid, e_aw);
      check("wvalid", axi.wvalid, e_w);
      check("bready", axi.bready, e_b);
      check("arvalid", axi.arvalid, e_ar);
      check("rready", axi.rready, e_r);
      if (e_aw) begin
         check("awaddr", axi.awaddr, t_addr);
         check("awprot", axi.awprot, 3'b000);
      end
      if (e_w) begin
         check("wdata", axi.wdata, t_data);
         check("wstrb", axi.wstrb, t_strb);
      end
      if (e_ar) begin
         check("araddr", axi.araddr, t_addr);
         check("arprot", axi.arprot, 3'b000);
      end
      exp_rsp = '0;
      if (busy && cyc == t_rsp) exp_rsp[t_own] = 1'b1;
      check("rsp_valid", o_rsp_valid, exp_rsp);
      if (exp_rsp != '0) begin
         check("rsp_rdata", o_rsp_rdata, t_we ? 32'h0 : t_rdata);
         check("rsp_resp", o_rsp_resp, t_resp);
      end
      // advance the model to the next cycle
      if (rst_now) begin
         busy  = 1'b0;
         ptr_m = 0;
      end else begin
         if (busy && t_we && cyc == t_b) begin
            for (int k = 0; k < 4; k++)
               if (t_strb[k]) mem[t_addr[5:2]][k*8 +: 8] = t_data[k*8 +: 8];
         end
         if (busy && cyc == t_rsp) begin
            busy = 1'b0;
            rsp_log.push_back('{t_own, t_we ? 32'h0 : t_rdata, t_resp, t_acc, t_rsp});
         end else if (win >= 0) begin
            busy   = 1'b1;
            t_we   = cur[win].we;   t_own  = win;
            t_addr = cur[win].addr; t_data = cur[win].data; t_strb = cur[win].strb;
            t_acc  = cyc;
            t_resp = (cfg_resp < 0) ? ($urandom_range(0, 1) ? 2'b10 : 2'b00) : 2'(cfg_resp);
            t_aw   = cyc + 1 + dly(cfg_daw);
            t_w    = cyc + 1 + dly(cfg_dw);
            t_b    = ((t_aw > t_w) ? t_aw : t_w) + 1 + dly(cfg_db);
            t_ar   = cyc + 1 + dly(cfg_dar);
            t_r    = t_ar + 1 + dly(cfg_dr);
            t_rsp  = (t_we ? t_b : t_r) + 1;
            ptr_m  = (win + 1) % NUM_REQ;
            pend[win] = 1'b0;
            gap[win]  = (cfg_gap_max == 0) ? 0 : int'($urandom_range(0, cfg_gap_max));
            grant_log.push_back(win);
         end
      end
      for (int n = 0; n < NUM_REQ; n++) begin
         if (!pend[n]) begin
            if (gap[n] > 0) gap[n]--;
            else if (req_q[n].size() > 0) begin
               cur[n]  = req_q[n].pop_front();
               pend[n] = 1'b1;
            end
         end
      end
      cyc++;
   endtask

   task automatic drain(input int budget);
      bit active;
      int n;
      n = 0;
      active = 1'b1;
      while (active && n < budget) begin
         step();
         n++;
         active = busy || pend[0] || pend[1] || req_q[0].size() > 0 || req_q[1].size() > 0;
      end
      check("drain_timeout", active, 1'b0);
   endtask

   task automatic reset_pulse();
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
   endtask

   function automatic void cfg_zero(input int resp);
      cfg_rand = 1'b0; cfg_daw = 0; cfg_dw = 0; cfg_db = 0; cfg_dar = 0; cfg_dr = 0;
      cfg_resp = resp; cfg_gap_max = 0;
   endfunction

   initial begin
      int base, nlog;
      checks = 0; errors = 0; cyc = 0; busy = 1'b0; ptr_m = 0; rst_req = 1'b0;
      t_we = 1'b0; t_own = 0; t_addr = '0; t_data = '0; t_rdata = '0; t_strb = '0; t_resp = 2'b00;
      t_acc = -10; t_aw = -10; t_w = -10; t_b = -10; t_ar = -10; t_r = -10; t_rsp = -10;
      for (int n = 0; n < NUM_REQ; n++) begin
         pend[n] = 1'b0; gap[n] = 0; cur[n] = mk(1'b0, 32'h0, 32'h0);
      end
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      cfg_zero(0);
      i_req_valid = '0; i_req_we = '0; i_req_addr = '0; i_req_wdata = '0; i_req_wstrb = '0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
      i_sync_rst = 1'b1;
      @(posedge i_clk);
      reset_pulse();
      check("rst_rsp_valid", o_rsp_valid, 2'b00);
      check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
      check("rst_rsp_resp", o_rsp_resp, 2'b00);

      // zero-wait write then read-back from requester 0
      base = rsp_log.size();
      req_q[0].push_back(mk(1'b1, 32'h4, 32'h12345678));
      req_q[0].push_back(mk(1'b0, 32'h4, 32'h0));
      drain(100);
      check("t1_len", rsp_log.size() - base, 2);
      if (rsp_log.size() >= base + 2) begin
         check("t1_wr_lat", rsp_log[base].rsp - rsp_log[base].acc, 3);
         check("t1_wr_owner", rsp_log[base].own, 0);
         check("t1_next_acc", rsp_log[base+1].acc - rsp_log[base].acc, 4);
         check("t1_rd_data", rsp_log[base+1].rdata, 32'h12345678);
         check("t1_rd_lat", rsp_log[base+1].rsp - rsp_log[base+1].acc, 3);
      end

      // two continuous requesters alternate after reset
      reset_pulse();
      base = grant_log.size();
      for (int i = 0; i < 4; i++) begin
         req_q[0].push_back(mk(1'b1, 32'(16 + 4*i), $urandom));
         req_q[1].push_back(mk(1'b1, 32'(32 + 4*i), $urandom));
      end
      drain(200);
      check("t2_len", grant_log.size() - base, 8);
      for (int i = 0; i < 8 && base + i < grant_log.size(); i++)
         check("t2_grant_order", grant_log[base+i], i % 2);

      // W completes three cycles before AW
      cfg_daw = 3; cfg_dw = 0;
      base = rsp_log.size();
      req_q[0].push_back(mk(1'b1, 32'h10, 32'hA5A5_0F0F));
      drain(100);
      if (rsp_log.size() > base) check("t3_lat", rsp_log[base].rsp - rsp_log[base].acc, 6);
      else check("t3_len", rsp_log.size() - base, 1);

      // slow read with SLVERR on requester 1
      cfg_zero(0);
      req_q[1].push_back(mk(1'b1, 32'h8, 32'hDEADBEEF));
      drain(100);
      cfg_dr = 5; cfg_resp = 2;
      base = rsp_log.size();
      req_q[1].push_back(mk(1'b0, 32'h8, 32'h0));
      drain(100);
      if (rsp_log.size() > base) begin
         check("t4_rdata", rsp_log[base].rdata, 32'hDEADBEEF);
         check("t4_resp", rsp_log[base].resp, 2'b10);
         check("t4_owner", rsp_log[base].own, 1);
         check("t4_lat", rsp_log[base].rsp - rsp_log[base].acc, 8);
      end else check("t4_len", rsp_log.size() - base, 1);

      // three back-to-back reads from requester 1 only
      cfg_zero(0);
      base = rsp_log.size();
      for (int i = 0; i < 3; i++) req_q[1].push_back(mk(1'b0, 32'(4*i), 32'h0));
      drain(100);
      check("t5_len", rsp_log.size() - base, 3);
      for (int i = 1; i < 3 && base + i < rsp_log.size(); i++) begin
         check("t5_acc_after_rsp", rsp_log[base+i].acc - rsp_log[base+i-1].rsp, 1);
         check("t5_owner", rsp_log[base+i].own, 1);
      end

      // reset while waiting for B abandons the write and restores the pointer
      cfg_db = 6;
      req_q[0].push_back(mk(1'b1, 32'h20, 32'h0BAD_0BAD));
      for (int n = 0; n < 20 && !(busy && t_we && cyc > t_aw && cyc > t_w && cyc < t_b); n++) step();
      check("t6_reached_wr_b", busy && t_we && cyc < t_b, 1'b1);
      nlog = rsp_log.size();
      reset_pulse();
      step();
      check("t6_no_rsp", rsp_log.size() - nlog, 0);
      cfg_zero(0);
      base = grant_log.size();
      req_q[0].push_back(mk(1'b0, 32'h4, 32'h0));
      req_q[1].push_back(mk(1'b0, 32'h4, 32'h0));
      drain(100);
      if (grant_log.size() > base) check("t6_first_grant", grant_log[base], 0);
      else check("t6_len", grant_log.size() - base, 2);

      // randomised traffic
      cfg_rand = 1'b1; cfg_resp = -1; cfg_gap_max = 3;
      for (int i = 0; i < 60; i++) begin
         req_q[0].push_back(rand_cmd());
         req_q[1].push_back(rand_cmd());
      end
      drain(5000);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
